// File: rtl/count_seq_pkg.sv
// Shared constants, types and helpers for the count-sequence tracker.
package count_seq_pkg;

  localparam int unsigned SEQ_LEN = 15;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned DIG_MAX = 9;
  localparam int unsigned NUM_MV  = 4;

  // Digit shown by the counter at each position.
  localparam logic [DIG_W-1:0] SEQ [SEQ_LEN] = '{
    4'd3, 4'd2, 4'd6, 4'd8, 4'd8, 4'd0, 4'd5, 4'd4,
    4'd4, 4'd7, 4'd4, 4'd5, 4'd0, 4'd1, 4'd8
  };

  // Move offsets expressed as forward rotations modulo SEQ_LEN.
  localparam int unsigned OFS_STEP    = 1;
  localparam int unsigned OFS_REV     = SEQ_LEN - 2;
  localparam int unsigned OFS_SKIP    = 5;
  localparam int unsigned OFS_SKIPREV = SEQ_LEN - 6;

  typedef enum logic [1:0] {
    MV_STEP    = 2'b00,
    MV_REV     = 2'b01,
    MV_SKIP    = 2'b10,
    MV_SKIPREV = 2'b11
  } move_t;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } st_t;

  typedef logic [SEQ_LEN-1:0] pmask_t;

  // Rotate a position mask forward by k positions (bit p moves to p+k mod 15).
  function automatic pmask_t rot15(input pmask_t m, input int unsigned k);
    logic [2*SEQ_LEN-1:0] d;
    d = {m, m} << k;
    return d[2*SEQ_LEN-1 -: SEQ_LEN];
  endfunction

  function automatic int unsigned move_ofs(input move_t mv);
    case (mv)
      MV_STEP:    return OFS_STEP;
      MV_REV:     return OFS_REV;
      MV_SKIP:    return OFS_SKIP;
      default:    return OFS_SKIPREV;
    endcase
  endfunction

  function automatic logic is_onehot(input pmask_t m);
    return (m != '0) && ((m & (m - pmask_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/count_seq_match.sv
// Combinational digit -> mask of sequence positions showing that digit.
module count_seq_match
  import count_seq_pkg::*;
(
  input  logic [DIG_W-1:0] iV,
  output pmask_t           oMatch_c
);

  always_comb begin
    oMatch_c = '0;
    for (int unsigned p = 0; p < SEQ_LEN; p++) begin
      oMatch_c[p] = (iV == SEQ[p]);
    end
  end

endmodule

// File: rtl/count_sequence_tracker.sv
// Recovers skip/reverse counter position and per-step move from its digit stream.
// Optional saturating error counter port enabled by COUNT_TRACKER_ERRCNT_EN.
module count_sequence_tracker
  import count_seq_pkg::*;
#(
`ifdef COUNT_TRACKER_ERRCNT_EN
  parameter int unsigned ERR_CNT_W = 8
`endif
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  input  logic [DIG_W-1:0] iV,
  output logic             oLocked,
  output logic [POS_W-1:0] oState,
  output logic             oMoveVld,
  output logic             oSkip,
  output logic             oRev,
  output logic             oErr
`ifdef COUNT_TRACKER_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] oErrCnt
`endif
);

  st_t              state, state_nxt;
  pmask_t           mask, mask_nxt;
  pmask_t           match_c, reach_c, nxt_c;
  logic [2:0]       hits_c;
  move_t            mv_c;
  logic             err_nxt, mv_vld_nxt, skip_nxt, rev_nxt, locked_nxt;
  logic [POS_W-1:0] pos_nxt;

  count_seq_match u_match (
    .iV       (iV),
    .oMatch_c (match_c)
  );

  // Candidate set reachable by any legal move, narrowed by the sampled digit.
  always_comb begin
    reach_c = '0;
    for (int unsigned m = 0; m < NUM_MV; m++) begin
      reach_c = reach_c | rot15(mask, move_ofs(move_t'(2'(m))));
    end
    nxt_c = reach_c & match_c;
  end

  // Move decode: count offsets that carry the old position onto the new one.
  always_comb begin
    hits_c = '0;
    mv_c   = MV_STEP;
    for (int unsigned m = 0; m < NUM_MV; m++) begin
      if (rot15(mask, move_ofs(move_t'(2'(m)))) == nxt_c) begin
        hits_c = hits_c + 3'd1;
        mv_c   = move_t'(2'(m));
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask;
    err_nxt    = 1'b0;
    mv_vld_nxt = 1'b0;
    skip_nxt   = 1'b0;
    rev_nxt    = 1'b0;
    if (iValid) begin
      case (state)
        ACQ: begin
          mask_nxt = match_c;
          if (match_c != '0) state_nxt = TRACK;
          else               err_nxt   = 1'b1;
        end
        default: begin
          if ((nxt_c == '0) || (iV > DIG_W'(DIG_MAX))) begin
            err_nxt   = 1'b1;
            mask_nxt  = match_c;
            state_nxt = ACQ;
          end else begin
            mask_nxt = nxt_c;
            if (is_onehot(mask) && is_onehot(nxt_c) && (hits_c == 3'd1)) begin
              mv_vld_nxt = 1'b1;
              skip_nxt   = mv_c[1];
              rev_nxt    = mv_c[0];
            end
          end
        end
      endcase
    end
  end

  // Lock indication and position index of the next mask.
  always_comb begin
    locked_nxt = is_onehot(mask_nxt);
    pos_nxt    = '0;
    if (locked_nxt) begin
      for (int unsigned p = 0; p < SEQ_LEN; p++) begin
        if (mask_nxt[p]) pos_nxt = POS_W'(p);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= ACQ;
      mask     <= '0;
      oLocked  <= 1'b0;
      oState   <= '0;
      oMoveVld <= 1'b0;
      oSkip    <= 1'b0;
      oRev     <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask     <= mask_nxt;
      oLocked  <= locked_nxt;
      oState   <= pos_nxt;
      oMoveVld <= mv_vld_nxt;
      oSkip    <= skip_nxt;
      oRev     <= rev_nxt;
      oErr     <= err_nxt;
    end
  end

`ifdef COUNT_TRACKER_ERRCNT_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oErrCnt <= '0;
    end else if (err_nxt && (oErrCnt != '1)) begin
      oErrCnt <= oErrCnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_count_sequence_tracker.sv
// Randomized self-checking bench for count_sequence_tracker against a set-based model.
module tb_count_sequence_tracker;

  logic       iClk;
  logic       iRst;
  logic       iValid;
  logic [3:0] iV;
  logic       oLocked;
  logic [3:0] oState;
  logic       oMoveVld, oSkip, oRev, oErr;
`ifdef COUNT_TRACKER_ERRCNT_EN
  logic [7:0] oErrCnt;
`endif

  int total = 0;
  int bad   = 0;

  count_sequence_tracker dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iValid   (iValid),
    .iV       (iV),
    .oLocked  (oLocked),
    .oState   (oState),
    .oMoveVld (oMoveVld),
    .oSkip    (oSkip),
    .oRev     (oRev),
    .oErr     (oErr)
`ifdef COUNT_TRACKER_ERRCNT_EN
    ,
    .oErrCnt  (oErrCnt)
`endif
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference model: explicit set of candidate positions and signed moves.
  int seq   [15] = '{3, 2, 6, 8, 8, 0, 5, 4, 4, 7, 4, 5, 0, 1, 8};
  int moves [4]  = '{1, -2, 5, -6};
  bit cand  [15];
  bit m_track;
  bit e_locked, e_mv, e_skip, e_rev, e_err;
  int e_state;
  int e_errcnt;

  function automatic logic [8:0] pack(input logic lk, input logic [3:0] st, input logic mv,
                                      input logic sk, input logic rv, input logic er);
    return {lk, (lk ? st : 4'd0), mv, mv & sk, mv & rv, er};
  endfunction

  task automatic model_refresh();
    int n;
    n = 0;
    e_state = 0;
    for (int p = 0; p < 15; p++) if (cand[p]) begin n++; e_state = p; end
    e_locked = (n == 1);
    if (!e_locked) e_state = 0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < 15; p++) cand[p] = 1'b0;
    m_track = 0; e_mv = 0; e_skip = 0; e_rev = 0; e_err = 0; e_errcnt = 0;
    model_refresh();
  endtask

  task automatic model_idle();
    e_mv = 0; e_skip = 0; e_rev = 0; e_err = 0;
  endtask

  task automatic model_sample(input int v);
    bit mt [15];
    bit nx [15];
    int n_old, n_new, p_old, p_new, any, hits, hit_k;
    model_idle();
    any = 0;
    for (int q = 0; q < 15; q++) begin
      mt[q] = (v <= 9) && (seq[q] == v);
      if (mt[q]) any = 1;
    end
    if (!m_track) begin
      cand = mt;
      if (any != 0) m_track = 1; else e_err = 1;
    end else begin
      n_old = 0; n_new = 0; p_old = 0; p_new = 0;
      for (int q = 0; q < 15; q++) begin
        nx[q] = 1'b0;
        if (cand[q]) begin n_old++; p_old = q; end
      end
      for (int p = 0; p < 15; p++)
        if (cand[p])
          for (int k = 0; k < 4; k++)
            if (mt[(p + moves[k] + 15) % 15]) nx[(p + moves[k] + 15) % 15] = 1'b1;
      for (int q = 0; q < 15; q++) if (nx[q]) begin n_new++; p_new = q; end
      if (n_new == 0 || v > 9) begin
        e_err = 1; cand = mt; m_track = 0;
      end else begin
        if (n_old == 1 && n_new == 1) begin
          hits = 0; hit_k = 0;
          for (int k = 0; k < 4; k++)
            if ((p_old + moves[k] + 15) % 15 == p_new) begin hits++; hit_k = k; end
          if (hits == 1) begin
            e_mv = 1; e_skip = (hit_k >= 2); e_rev = (hit_k == 1 || hit_k == 3);
          end
        end
        cand = nx;
      end
    end
    if (e_err && e_errcnt < 255) e_errcnt++;
    model_refresh();
  endtask

  // Stimulus: inputs change on the falling edge, outputs read 1 time unit after the rising edge.
  task automatic drive(input int v);
    @(negedge iClk);
    iValid = 1'b1;
    iV     = 4'(v);
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    model_sample(v);
  endtask

  task automatic idle();
    @(negedge iClk);
    iValid = 1'b0;
    @(posedge iClk);
    #1;
    model_idle();
  endtask

  task automatic do_reset(input logic with_valid);
    @(negedge iClk);
    iRst   = 1'b1;
    iValid = with_valid;
    iV     = 4'd3;
    @(posedge iClk);
    #1;
    model_reset();
    @(negedge iClk);
    iRst   = 1'b0;
    iValid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++;
    if ({oLocked, oState, oMoveVld, oSkip, oRev, oErr} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", {oLocked, oState, oMoveVld, oSkip, oRev, oErr}, 9'd0);
    end
`ifdef COUNT_TRACKER_ERRCNT_EN
    total++;
    if (oErrCnt !== 8'd0) begin bad++; $display("FAIL reset_errcnt: got %0d want 0", oErrCnt); end
`endif
  endtask

  task automatic test_directed();
    int vs [9] = '{3, 2, 5, 8, 1, 9, 3, 8, 3};
    logic [8:0] exp_v, obs_v;
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(vs[i]);
      exp_v = pack(e_locked, 4'(e_state), e_mv, e_skip, e_rev, e_err);
      obs_v = pack(oLocked, oState, oMoveVld, oSkip, oRev, oErr);
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL directed step %0d (iV=%0d): got %b want %b", i, vs[i], obs_v, exp_v);
      end
      // Hand-derived checkpoints along the walk 0 -> 1 -> 6 -> 4 -> 13 -> error.
      if (i == 1) begin
        total++;
        if ({oLocked, oState, oMoveVld, oSkip, oRev} !== {1'b1, 4'd1, 1'b1, 2'b00}) begin
          bad++; $display("FAIL step_move: got st=%0d mv=%b sr=%b%b", oState, oMoveVld, oSkip, oRev);
        end
      end
      if (i == 2) begin
        total++;
        if ({oState, oMoveVld, oSkip, oRev} !== {4'd6, 1'b1, 2'b10}) begin
          bad++; $display("FAIL skip_move: got st=%0d mv=%b sr=%b%b", oState, oMoveVld, oSkip, oRev);
        end
      end
      if (i == 3) begin
        total++;
        if ({oState, oMoveVld, oSkip, oRev} !== {4'd4, 1'b1, 2'b01}) begin
          bad++; $display("FAIL rev_move: got st=%0d mv=%b sr=%b%b", oState, oMoveVld, oSkip, oRev);
        end
      end
      if (i == 4) begin
        total++;
        if ({oState, oMoveVld, oSkip, oRev} !== {4'd13, 1'b1, 2'b11}) begin
          bad++; $display("FAIL skiprev_move: got st=%0d mv=%b sr=%b%b", oState, oMoveVld, oSkip, oRev);
        end
      end
      if (i == 5) begin
        total++;
        if ({oErr, oLocked, oMoveVld} !== 3'b100) begin
          bad++; $display("FAIL bad_digit: got err=%b lk=%b mv=%b want 1 0 0", oErr, oLocked, oMoveVld);
        end
      end
    end
  endtask

  task automatic test_ambiguous();
    do_reset(1'b0);
    drive(8);
    total++;
    if ({oLocked, oErr} !== 2'b00) begin
      bad++; $display("FAIL amb_first: got lk=%b err=%b want 0 0", oLocked, oErr);
    end
    drive(8);
    total++;
    if ({oLocked, oState, oMoveVld, oErr} !== {1'b1, 4'd4, 1'b0, 1'b0}) begin
      bad++; $display("FAIL amb_resolve: got lk=%b st=%0d mv=%b err=%b want 1 4 0 0", oLocked, oState, oMoveVld, oErr);
    end
  endtask

  task automatic test_idle_hold();
    logic [8:0] exp_v, obs_v;
    do_reset(1'b0);
    drive(3);
    drive(2);
    for (int i = 0; i < 3; i++) begin
      idle();
      exp_v = pack(e_locked, 4'(e_state), e_mv, e_skip, e_rev, e_err);
      obs_v = pack(oLocked, oState, oMoveVld, oSkip, oRev, oErr);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL idle_hold %0d: got %b want %b", i, obs_v, exp_v);
      end
    end
    drive(6);
    total++;
    if ({oLocked, oState, oMoveVld, oSkip, oRev} !== {1'b1, 4'd2, 1'b1, 2'b00}) begin
      bad++; $display("FAIL resume_after_idle: got st=%0d mv=%b sr=%b%b", oState, oMoveVld, oSkip, oRev);
    end
  endtask

  task automatic test_reset_mid();
    drive(3);
    drive(2);
    do_reset(1'b1);
    total++;
    if ({oLocked, oState, oMoveVld, oSkip, oRev, oErr} !== 9'd0) begin
      bad++;
      $display("FAIL reset_mid: got %b want %b", {oLocked, oState, oMoveVld, oSkip, oRev, oErr}, 9'd0);
    end
  endtask

  task automatic test_random();
    int pos, r, k, v;
    logic [8:0] exp_v, obs_v;
    do_reset(1'b0);
    pos = $urandom_range(0, 14);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1'b1);
      end else if (r < 15) begin
        idle();
      end else begin
        if (r < 23) begin
          v = $urandom_range(0, 15);
        end else begin
          k = $urandom_range(0, 3);
          pos = (pos + moves[k] + 15) % 15;
          v = seq[pos];
        end
        drive(v);
      end
      exp_v = pack(e_locked, 4'(e_state), e_mv, e_skip, e_rev, e_err);
      obs_v = pack(oLocked, oState, oMoveVld, oSkip, oRev, oErr);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL random %0d: got %b want %b", i, obs_v, exp_v);
      end
`ifdef COUNT_TRACKER_ERRCNT_EN
      total++;
      if (oErrCnt !== 8'(e_errcnt)) begin
        bad++; $display("FAIL random_errcnt %0d: got %0d want %0d", i, oErrCnt, e_errcnt);
      end
`endif
    end
  endtask

`ifdef COUNT_TRACKER_ERRCNT_EN
  task automatic test_errcnt_sat();
    do_reset(1'b0);
    for (int i = 0; i < 260; i++) drive(9);
    total++;
    if (oErrCnt !== 8'hFF || e_errcnt != 255) begin
      bad++; $display("FAIL errcnt_sat: got %0d want 255", oErrCnt);
    end
  endtask
`endif

  initial begin
    iRst   = 1'b1;
    iValid = 1'b0;
    iV     = 4'd0;
    model_reset();
    repeat (2) @(posedge iClk);
    test_reset();
    test_directed();
    test_ambiguous();
    test_idle_hold();
    test_reset_mid();
    test_random();
`ifdef COUNT_TRACKER_ERRCNT_EN
    test_errcnt_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
